// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between icache fills and dcache fills/stores.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the dcache wins every tie.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ic_req,
    input  logic [ADDRESS_WIDTH-1:0]    ic_addr,
    output logic                        ic_fill_valid,
    output logic [CACHE_LINE_WIDTH-1:0] ic_fill_data,
    input  logic                        dc_req,
    input  logic                        dc_store,
    input  logic [ADDRESS_WIDTH-1:0]    dc_addr,
    input  logic [DATA_WIDTH-1:0]       dc_store_data,
    output logic                        dc_fill_valid,
    output logic [CACHE_LINE_WIDTH-1:0] dc_fill_data,
    output logic                        mem_req,
    output logic                        mem_store,
    output logic [ADDRESS_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_store_data,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_fill_data,
    input  logic                        mem_fill_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    logic [1:0]               state_d, state_q;
    logic                     last_grant_d, last_grant_q;
    logic                     mem_req_d, mem_req_q;
    logic                     mem_store_d, mem_store_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_store_data_d, mem_store_data_q;
    logic                     grant_dc_s;

    // Winner selection among pending requests
    always_comb begin
        grant_dc_s = 1'b0;
        if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_dc_s = (last_grant_q == GRANT_IC);
`else
            grant_dc_s = 1'b1;
`endif
        end else if (dc_req) begin
            grant_dc_s = 1'b1;
        end else begin
            grant_dc_s = 1'b0;
        end
    end

    // Next-state and memory-request register logic
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        mem_req_d        = mem_req_q;
        mem_store_d      = mem_store_q;
        mem_addr_d       = mem_addr_q;
        mem_store_data_d = mem_store_data_q;
        case (state_q)
            ST_IDLE: begin
                if (ic_req || dc_req) begin
                    mem_req_d = 1'b1;
                    if (grant_dc_s) begin
                        state_d          = ST_BUSY_D;
                        last_grant_d     = GRANT_DC;
                        mem_store_d      = dc_store;
                        mem_addr_d       = dc_addr;
                        mem_store_data_d = dc_store_data;
                    end else begin
                        state_d          = ST_BUSY_I;
                        last_grant_d     = GRANT_IC;
                        mem_store_d      = 1'b0;
                        mem_addr_d       = ic_addr;
                        mem_store_data_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // Requester inputs are deliberately ignored here; only memory completion moves on
                if (mem_fill_valid) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= GRANT_IC;
            mem_req_q        <= 1'b0;
            mem_store_q      <= 1'b0;
            mem_addr_q       <= {ADDRESS_WIDTH{1'b0}};
            mem_store_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            mem_req_q        <= mem_req_d;
            mem_store_q      <= mem_store_d;
            mem_addr_q       <= mem_addr_d;
            mem_store_data_q <= mem_store_data_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_store      = mem_store_q;
    assign mem_addr       = mem_addr_q;
    assign mem_store_data = mem_store_data_q;

    assign ic_fill_valid  = mem_fill_valid && (state_q == ST_BUSY_I);
    assign dc_fill_valid  = mem_fill_valid && (state_q == ST_BUSY_D);
    assign ic_fill_data   = mem_fill_data;
    assign dc_fill_data   = mem_fill_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory transactions are queued when requests are
// driven and checked when the arbiter presents them to the modelled memory.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_fill_valid;
    logic [LW-1:0] ic_fill_data;
    logic          dc_req;
    logic          dc_store;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_store_data;
    logic          dc_fill_valid;
    logic [LW-1:0] dc_fill_data;
    logic          mem_req;
    logic          mem_store;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_store_data;
    logic [LW-1:0] mem_fill_data;
    logic          mem_fill_valid;

    typedef struct {
        logic          is_dc;
        logic          store;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .CACHE_LINE_WIDTH(LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_fill_valid (ic_fill_valid),
        .ic_fill_data  (ic_fill_data),
        .dc_req        (dc_req),
        .dc_store      (dc_store),
        .dc_addr       (dc_addr),
        .dc_store_data (dc_store_data),
        .dc_fill_valid (dc_fill_valid),
        .dc_fill_data  (dc_fill_data),
        .mem_req       (mem_req),
        .mem_store     (mem_store),
        .mem_addr      (mem_addr),
        .mem_store_data(mem_store_data),
        .mem_fill_data (mem_fill_data),
        .mem_fill_valid(mem_fill_valid)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_dc, input logic store, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
        txn_t t;
        t.is_dc = is_dc;
        t.store = store;
        t.addr  = addr;
        t.data  = data;
        exp_q.push_back(t);
    endtask

    // Memory model: waits for a request, checks it against the scoreboard, answers after delay
    task automatic serve(input int delay, input logic [LW-1:0] line);
        txn_t e;
        int   n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (mem_req !== 1'b1) begin
            check("mem_req_timeout", mem_req, 1'b1);
            return;
        end
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e.addr);
        check("mem_store", mem_store, e.store);
        check("mem_store_data", mem_store_data, e.data);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("mem_req_held", mem_req, 1'b1);
            check("mem_addr_frozen", mem_addr, e.addr);
        end
        mem_fill_data  = line;
        mem_fill_valid = 1'b1;
        #1;
        check("ic_fill_valid", ic_fill_valid, !e.is_dc);
        check("dc_fill_valid", dc_fill_valid, e.is_dc);
        check("ic_fill_data", ic_fill_data, line);
        check("dc_fill_data", dc_fill_data, line);
        tick();
        mem_fill_valid = 1'b0;
        #1;
        check("done_mem_req", mem_req, 1'b0);
        check("done_valids", ic_fill_valid | dc_fill_valid, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        ic_req         = 1'b1;
        ic_addr        = 32'h0000_0200;
        dc_req         = 1'b1;
        dc_store       = 1'b0;
        dc_addr        = 32'h0000_0300;
        dc_store_data  = 32'h0000_1234;
        mem_fill_data  = {LW{1'b0}};
        mem_fill_valid = 1'b0;

        // Reset held with both requests pending
        repeat (2) tick();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_store", mem_store, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_store_data", mem_store_data, 32'h0);
        check("rst_ic_valid", ic_fill_valid, 1'b0);
        check("rst_dc_valid", dc_fill_valid, 1'b0);

        // Tie held for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b0, 32'h0000_0300, 32'h0000_1234);
        push(1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000);
        push(1'b1, 1'b0, 32'h0000_0300, 32'h0000_1234);
        push(1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000);
`else
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h0000_0300, 32'h0000_1234);
`endif
        rst_n = 1'b1;
        tick();
        check("grant_latency", mem_req, 1'b1);
        for (int i = 0; i < 4; i++) serve(1, {4{32'h1111_0000 + i}});
        ic_req = 1'b0;
        dc_req = 1'b0;
        tick();

        // Icache fill alone
        ic_req  = 1'b1;
        ic_addr = 32'h0000_0100;
        push(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000);
        tick();
        check("ic_grant_latency", mem_req, 1'b1);
        serve(3, {4{32'hAAAA_AAAA}});
        ic_req = 1'b0;
        tick();
        check("idle_mem_req", mem_req, 1'b0);

        // Stray completion in IDLE
        mem_fill_valid = 1'b1;
        #1;
        check("stray_idle_ic", ic_fill_valid, 1'b0);
        check("stray_idle_dc", dc_fill_valid, 1'b0);
        tick();
        mem_fill_valid = 1'b0;
        check("stray_idle_mem_req", mem_req, 1'b0);

        // Dcache store; inputs change while busy
        dc_req        = 1'b1;
        dc_store      = 1'b1;
        dc_addr       = 32'h0000_0040;
        dc_store_data = 32'hDEAD_BEEF;
        push(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        check("dc_grant_latency", mem_req, 1'b1);
        dc_addr       = 32'h0000_0080;
        dc_store_data = 32'h0BAD_F00D;
        dc_store      = 1'b0;
        serve(2, {LW{1'b0}});
        dc_req = 1'b0;

        // Stray completion in DONE
        mem_fill_valid = 1'b1;
        #1;
        check("stray_done_ic", ic_fill_valid, 1'b0);
        check("stray_done_dc", dc_fill_valid, 1'b0);
        tick();
        mem_fill_valid = 1'b0;
        check("stray_done_mem_req", mem_req, 1'b0);

        // Reset while BUSY_D, then a late completion
        dc_req  = 1'b1;
        dc_addr = 32'h0000_0500;
        tick();
        check("busy_d_mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_mem_req", mem_req, 1'b0);
        dc_req = 1'b0;
        rst_n  = 1'b1;
        tick();
        mem_fill_valid = 1'b1;
        #1;
        check("late_fill_dc", dc_fill_valid, 1'b0);
        check("late_fill_ic", ic_fill_valid, 1'b0);
        tick();
        mem_fill_valid = 1'b0;
        check("late_fill_mem_req", mem_req, 1'b0);

        ic_req  = 1'b1;
        ic_addr = 32'h0000_0600;
        push(1'b0, 1'b0, 32'h0000_0600, 32'h0000_0000);
        tick();
        check("post_rst_grant", mem_req, 1'b1);
        serve(1, {4{32'h5555_AAAA}});
        ic_req = 1'b0;
        tick();

        check("sb_drained", exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
